button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Input-side counterpart of the LED blinker: reads raw push-buttons/switches from board pins and turns them into clean, debounced level and edge signals.
- Synchronises each pin into the `clk` domain, filters contact bounce with a per-button stability counter, and emits one-cycle press/release pulses.
- Keeps a wrapping press-event counter sized to drive the LED bank directly.

Parameters:
- N_BTNS, 2, number of button inputs (≥1).
- DEBOUNCE_CYCLES, 100000, consecutive cycles a new synchronised level must persist before acceptance (10 ms at 10 MHz); must be ≥2.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board buttons); 0 = pin reads 1 when pressed.
- CNT_W, 8, width of press_count.
- LONG_CYCLES, 10000000, hold time for the long-press pulse (1 s at 10 MHz); used only with BTN_LONGPRESS_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- btn  in  N_BTNS  raw asynchronous button pins, polarity per ACTIVE_LOW.
- btn_state  out  N_BTNS  debounced level, 1 = pressed.
- btn_press  out  N_BTNS  one-cycle pulse on accepted press.
- btn_release  out  N_BTNS  one-cycle pulse on accepted release.
- press_count  out  CNT_W  running count of accepted presses, all buttons.
- btn_long  out  N_BTNS  one-cycle long-press pulse; present only with BTN_LONGPRESS_EN.

Behaviour:
- Reset: applied asynchronously on rst high; every register clears while rst is high.
  - Sync flops take the released pin level (1 if ACTIVE_LOW, else 0).
  - stable = 0; debounce counters = 0.
  - btn_state, btn_press, btn_release, press_count, btn_long all = 0.
- Synchroniser: two flops per bit. The pin is polarity-normalised to logical "pressed = 1" after the second flop.
- Per-button debounce, width $clog2(DEBOUNCE_CYCLES):
  - sync2 == stable: count <= 0.
  - sync2 != stable and count < DEBOUNCE_CYCLES-1: count <= count+1.
  - sync2 != stable and count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0, and fire press (0→1) or release (1→0).
  - Any single-cycle return to the stable level restarts the count from 0.
- Latency: a clean pin transition updates btn_state on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new level as edge 1.
- Pulses: btn_press and btn_release are registered and high for exactly the one cycle in which btn_state first shows the new value. They are never high simultaneously on one bit.
- press_count: each cycle adds popcount(btn_press), modulo 2^CNT_W.
  - Simultaneous presses on k buttons add k in one cycle.
  - Wrap-around is silent.
  - Releases never change it.
- Buttons are fully independent; no priority and no cross-coupling.
- Reset mid-debounce: partial counts are discarded. A button still held when rst deasserts is accepted as a fresh press after the full latency.

Optional Feature:
- Macro: BTN_LONGPRESS_EN.
- Defined:
  - Per-button hold counter, width $clog2(LONG_CYCLES+1), cleared while btn_state = 0; it starts counting on the cycle after btn_press.
  - btn_long pulses for one cycle exactly LONG_CYCLES cycles after btn_press, provided btn_state stayed 1 throughout.
  - The counter then saturates: no repeat pulse until release and a new press.
  - Release before LONG_CYCLES produces no btn_long.
  - Reset clears the counter.
- Undefined: btn_long port and hold counters do not exist; all other behaviour is unchanged.

Test Plan (bench parameters: N_BTNS=2, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, CNT_W=8, LONG_CYCLES=20):
- Clean press: btn[0] 1→0 sampled at edge 1 → btn_state[0]=1 after edge 10, btn_press[0]=1 for that single cycle, press_count 0→1; btn[1] outputs stay 0.
- Bounce: btn[0] low 3 cycles, high 2, low 5, high 1, then low steady → no pulse during the bounce; btn_press[0] fires exactly once, 10 edges after the final low sample.
- Release: from pressed, btn[0] 0→1 steady → btn_release[0] one cycle at edge 10, btn_state[0]=0, press_count unchanged.
- Simultaneous and wrap: preload press_count to 255 via 255 presses, then press both buttons on the same edge → btn_press=2'b11 in one cycle, press_count=1.
- Reset mid-debounce: assert rst at count 5 with btn[0] held low, deassert after 3 cycles → all outputs 0 during reset; btn_press[0] fires 10 edges after the first post-reset edge.
- Long press (BTN_LONGPRESS_EN): hold btn[1] 40 cycles → btn_long[1] single pulse 20 cycles after btn_press[1], none afterwards; hold 15 cycles then release → no btn_long.

Source files
------------

// File: rtl/button_debounce.sv
// Two-flop synchroniser, per-button stability filter, press/release pulses and a press counter.
// Define BTN_LONGPRESS_EN to add the per-button btn_long hold-time pulse output.
module button_debounce #(
  parameter int N_BTNS          = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTNS-1:0] btn,
  output logic [N_BTNS-1:0] btn_state,
  output logic [N_BTNS-1:0] btn_press,
  output logic [N_BTNS-1:0] btn_release,
  output logic [CNT_W-1:0]  press_count
`ifdef BTN_LONGPRESS_EN
  ,
  output logic [N_BTNS-1:0] btn_long
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTNS-1:0] RELEASED_PIN = {N_BTNS{ACTIVE_LOW}};

  logic [N_BTNS-1:0] sync1_q;
  logic [N_BTNS-1:0] sync2_q;
  logic [N_BTNS-1:0] level;

  // Reset to the idle pin level so a released button is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RELEASED_PIN;
      sync2_q <= RELEASED_PIN;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign level = sync2_q ^ RELEASED_PIN;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTNS; gi++) begin : g_btn
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            stable_q;
      logic            stable_d;
      logic            press_q;
      logic            press_d;
      logic            rel_q;
      logic            rel_d;

      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        if (level[gi] != stable_q) begin
          if (cnt_q == DB_LAST) begin
            stable_d = level[gi];
            press_d  = level[gi];
            rel_d    = ~level[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
          rel_q    <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          press_q  <= press_d;
          rel_q    <= rel_d;
        end
      end

      assign btn_state[gi]   = stable_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = rel_q;

`ifdef BTN_LONGPRESS_EN
      localparam int LG_W = $clog2(LONG_CYCLES + 1);
      localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
      localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);

      logic [LG_W-1:0] hold_q;
      logic [LG_W-1:0] hold_d;
      logic            long_q;
      logic            long_d;

      // Counter saturates at LONG_CYCLES so the pulse fires once per press.
      always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!stable_q) begin
          hold_d = '0;
        end else if (hold_q != LG_MAX) begin
          hold_d = hold_q + 1'b1;
          long_d = (hold_q == LG_LAST) && stable_d;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign btn_long[gi] = long_q;
`endif
    end
  endgenerate

  logic [CNT_W-1:0] press_count_q;
  logic [CNT_W-1:0] press_count_d;

  always_comb begin
    press_count_d = press_count_q;
    for (int i = 0; i < N_BTNS; i++) begin
      press_count_d = press_count_d + CNT_W'(btn_press[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count_q <= '0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: reset, clean press/release, bounce, wrap, reset mid-debounce, long press.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;
  logic [1:0] btn_state;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [7:0] press_count;
`ifdef BTN_LONGPRESS_EN
  logic [1:0] btn_long;
`endif

  int tests  = 0;
  int failed = 0;
  int n_press [2];
  int n_rel   [2];
  int n_long  [2];

  button_debounce #(
    .N_BTNS(2),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW(1'b1),
    .CNT_W(8),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .press_count(press_count)
`ifdef BTN_LONGPRESS_EN
    ,
    .btn_long(btn_long)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
      n_long[i]  = 0;
    end
  endtask

  // One rising edge, then sample 1 time unit later and tally pulses.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        n_press[i] += int'(btn_press[i]);
        n_rel[i]   += int'(btn_release[i]);
`ifdef BTN_LONGPRESS_EN
        n_long[i]  += int'(btn_long[i]);
`endif
      end
    end
  endtask

  task automatic set_pin(input int b, input logic v, input int n);
    btn[b] = v;
    cyc(n);
  endtask

  initial begin
    clear_counts();
    cyc(3);
    check_eq("rst_state", 32'(btn_state), 32'h0);
    check_eq("rst_press", 32'(btn_press), 32'h0);
    check_eq("rst_count", 32'(press_count), 32'h0);
    rst = 1'b0;
    cyc(4);
    check_eq("idle_state", 32'(btn_state), 32'h0);

    // Clean press on btn[0]
    clear_counts();
    btn[0] = 1'b0;
    cyc(9);
    check_eq("press_e9_state", 32'(btn_state), 32'h0);
    cyc(1);
    check_eq("press_e10_state", 32'(btn_state), 32'h1);
    check_eq("press_e10_pulse", 32'(btn_press), 32'h1);
    cyc(1);
    check_eq("press_e11_pulse", 32'(btn_press), 32'h0);
    cyc(1);
    check_eq("press_count_1", 32'(press_count), 32'd1);
    check_eq("press_n0", 32'(n_press[0]), 32'd1);
    check_eq("press_n1", 32'(n_press[1]), 32'd0);

    // Clean release
    clear_counts();
    btn[0] = 1'b1;
    cyc(9);
    check_eq("rel_e9_state", 32'(btn_state), 32'h1);
    cyc(1);
    check_eq("rel_e10_pulse", 32'(btn_release), 32'h1);
    check_eq("rel_e10_state", 32'(btn_state), 32'h0);
    check_eq("rel_e10_nopress", 32'(btn_press), 32'h0);
    cyc(2);
    check_eq("rel_count", 32'(press_count), 32'd1);
    check_eq("rel_n0", 32'(n_rel[0]), 32'd1);

    // Bounce, then steady low
    clear_counts();
    set_pin(0, 1'b0, 3);
    set_pin(0, 1'b1, 2);
    set_pin(0, 1'b0, 5);
    set_pin(0, 1'b1, 1);
    check_eq("bounce_nopulse", 32'(n_press[0]), 32'd0);
    set_pin(0, 1'b0, 9);
    check_eq("bounce_e9", 32'(n_press[0]), 32'd0);
    cyc(1);
    check_eq("bounce_e10_pulse", 32'(btn_press), 32'h1);
    cyc(10);
    check_eq("bounce_once", 32'(n_press[0]), 32'd1);
    check_eq("bounce_count", 32'(press_count), 32'd2);
    set_pin(0, 1'b1, 12);

    // Bring press_count to 255, then press both on the same edge
    for (int k = 0; k < 253; k++) begin
      set_pin(0, 1'b0, 12);
      set_pin(0, 1'b1, 12);
    end
    check_eq("preload_255", 32'(press_count), 32'd255);
    clear_counts();
    btn = 2'b00;
    cyc(10);
    check_eq("both_pulse", 32'(btn_press), 32'h3);
    cyc(1);
    check_eq("wrap_count", 32'(press_count), 32'd1);
    btn = 2'b11;
    cyc(12);
    check_eq("both_rel_n0", 32'(n_rel[0]), 32'd1);
    check_eq("both_rel_n1", 32'(n_rel[1]), 32'd1);
    check_eq("rel_keeps_count", 32'(press_count), 32'd1);

    // Reset with the btn[0] debounce count at 5
    clear_counts();
    btn[0] = 1'b0;
    cyc(7);
    rst = 1'b1;
    #1;
    check_eq("midrst_state", 32'(btn_state), 32'h0);
    check_eq("midrst_count", 32'(press_count), 32'h0);
    cyc(3);
    check_eq("midrst_hold_press", 32'(btn_press), 32'h0);
    check_eq("midrst_hold_state", 32'(btn_state), 32'h0);
    rst = 1'b0;
    clear_counts();
    cyc(9);
    check_eq("postrst_e9", 32'(n_press[0]), 32'd0);
    cyc(1);
    check_eq("postrst_e10_pulse", 32'(btn_press), 32'h1);
    cyc(1);
    check_eq("postrst_count", 32'(press_count), 32'd1);
    set_pin(0, 1'b1, 12);

`ifdef BTN_LONGPRESS_EN
    // Long press on btn[1]: held 40 cycles after the accepted press
    clear_counts();
    btn[1] = 1'b0;
    cyc(10);
    check_eq("long_press_pulse", 32'(btn_press), 32'h2);
    cyc(19);
    check_eq("long_early", 32'(n_long[1]), 32'd0);
    cyc(1);
    check_eq("long_pulse", 32'(btn_long), 32'h2);
    cyc(20);
    check_eq("long_once", 32'(n_long[1]), 32'd1);
    set_pin(1, 1'b1, 12);
    check_eq("long_rel_once", 32'(n_long[1]), 32'd1);

    // Short hold: released 15 cycles after press, no long pulse
    clear_counts();
    btn[1] = 1'b0;
    cyc(10);
    check_eq("short_press_pulse", 32'(btn_press), 32'h2);
    set_pin(1, 1'b1, 15);
    cyc(20);
    check_eq("short_nolong", 32'(n_long[1]), 32'd0);
    check_eq("short_nolong0", 32'(n_long[0]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
